// File: rtl/branch_resolve_ctrl_pkg.sv
// rtl/branch_resolve_ctrl_pkg.sv - shared constants and types for ID-stage branch resolution
//
// Purpose: branch opcode constants, FSM state encoding, operand forward-select
// encoding and a helper telling which branches read rt.
// Ports: none (package).
package branch_resolve_ctrl_pkg;

    localparam logic [5:0] OP_BLTZ = 6'h01;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_BLEZ = 6'h06;
    localparam logic [5:0] OP_BGTZ = 6'h07;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } brState_t;

    typedef enum logic {
        FWD_RF  = 1'b0,
        FWD_MEM = 1'b1
    } fwdSel_t;

    // Only the two-register compares depend on rt; the zero compares ignore it.
    function automatic logic usesRt(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational branch condition evaluator
//
// Purpose: decodes the opcode into is_branch and evaluates the branch
// condition on already-resolved (forwarded) operands.
// Ports:
//   op        in   6   instruction bits 31:26
//   rsVal     in   DW  resolved rs operand
//   rtVal     in   DW  resolved rt operand
//   cond_true out  1   branch condition holds
//   is_branch out  1   opcode is one of the five conditional branches
module branch_cond_eval
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int DW = 32
)
(
    input  logic [5:0]    op,
    input  logic [DW-1:0] rsVal,
    input  logic [DW-1:0] rtVal,
    output logic          cond_true,
    output logic          is_branch
);

    // Kept separate from the condition block: the top uses is_branch to
    // choose the operands that feed the condition.
    assign is_branch = (op == OP_BLTZ) || (op == OP_BEQ) || (op == OP_BNE) ||
                       (op == OP_BLEZ) || (op == OP_BGTZ);

    always_comb begin
        cond_true = 1'b0;
        case (op)
            OP_BLTZ: cond_true = rsVal[DW-1];
            OP_BEQ:  cond_true = (rsVal == rtVal);
            OP_BNE:  cond_true = (rsVal != rtVal);
            OP_BLEZ: cond_true = rsVal[DW-1] || (rsVal == '0);
            OP_BGTZ: cond_true = !rsVal[DW-1] && (rsVal != '0);
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - ID-stage branch hazard, forwarding and resolution control
//
// Purpose: stalls the front end while a branch operand is still being produced
// in EX (or loaded in MEM), forwards MEM ALU results, and issues the PC
// redirect plus IF/ID flush when the branch resolves taken.
// Optional build macro: BRANCH_STATS_EN (statistics counters; ports tie to 0 otherwise).
// Ports:
//   clk, reset (async, active low)
//   id_valid, id_op, id_rs, id_rt, id_pc4, id_imm   ID instruction fields
//   rs_data, rt_data                                 register file read data
//   ex_regwrite, ex_memread, ex_rd                   EX producer
//   mem_regwrite, mem_memread, mem_rd, mem_alu       MEM producer
//   stall, br_taken, br_target, ifid_flush           pipeline control
//   stall_err                                        sticky stall-bound overrun
//   cnt_branch, cnt_taken, cnt_stall                 statistics
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int DW        = 32,
    parameter int RW        = 5,
    parameter int MAX_STALL = 2
)
(
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [5:0]    id_op,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [DW-1:0] id_pc4,
    input  logic [15:0]   id_imm,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] rt_data,
    input  logic          ex_regwrite,
    input  logic          ex_memread,
    input  logic [RW-1:0] ex_rd,
    input  logic          mem_regwrite,
    input  logic          mem_memread,
    input  logic [RW-1:0] mem_rd,
    input  logic [DW-1:0] mem_alu,
    output logic          stall,
    output logic          br_taken,
    output logic [DW-1:0] br_target,
    output logic          ifid_flush,
    output logic          stall_err,
    output logic [31:0]   cnt_branch,
    output logic [31:0]   cnt_taken,
    output logic [31:0]   cnt_stall
);

    localparam int CW = $clog2(MAX_STALL + 2);

    brState_t      state;
    logic [CW-1:0] stallCnt;
    logic          stallErr;

    logic          isBranch;
    logic          condTrue;
    logic          rsLive, rtLive;
    logic          rsHazEx, rsHazMld, rtHazEx, rtHazMld;
    logic          hazard;
    fwdSel_t       rsSel, rtSel;
    logic [DW-1:0] rsVal, rtVal;
    logic          overflow, active, stallNow, resolveNow, forceNow;
    logic          unusedExMemread;

    // An EX load already has ex_regwrite set, so it is caught by the EX check;
    // the second stall comes from the MEM-load check one cycle later.
    assign unusedExMemread = ex_memread;

    // $0 never carries a hazard or a forward.
    assign rsLive = isBranch && (id_rs != '0);
    assign rtLive = isBranch && usesRt(id_op) && (id_rt != '0);

    assign rsHazEx  = rsLive && ex_regwrite && (ex_rd == id_rs);
    assign rsHazMld = rsLive && mem_memread && (mem_rd == id_rs);
    assign rtHazEx  = rtLive && ex_regwrite && (ex_rd == id_rt);
    assign rtHazMld = rtLive && mem_memread && (mem_rd == id_rt);
    assign hazard   = rsHazEx || rsHazMld || rtHazEx || rtHazMld;

    // A younger EX write to the same register shadows the MEM value.
    assign rsSel = (rsLive && mem_regwrite && !mem_memread && (mem_rd == id_rs) && !rsHazEx)
                   ? FWD_MEM : FWD_RF;
    assign rtSel = (rtLive && mem_regwrite && !mem_memread && (mem_rd == id_rt) && !rtHazEx)
                   ? FWD_MEM : FWD_RF;
    assign rsVal = (rsSel == FWD_MEM) ? mem_alu : rs_data;
    assign rtVal = (rtSel == FWD_MEM) ? mem_alu : rt_data;

    branch_cond_eval #(.DW(DW)) u_cond (
        .op        (id_op),
        .rsVal     (rsVal),
        .rtVal     (rtVal),
        .cond_true (condTrue),
        .is_branch (isBranch)
    );

    // Another stall would push this branch past its budget: resolve now instead.
    assign overflow   = (state == ST_WAIT) && (stallCnt >= CW'(MAX_STALL));
    assign active     = reset && id_valid && isBranch;
    assign stallNow   = active && hazard && !overflow;
    assign forceNow   = active && hazard && overflow;
    assign resolveNow = active && !stallNow;

    assign stall      = stallNow;
    assign br_taken   = resolveNow && condTrue;
    assign ifid_flush = resolveNow && condTrue;
    assign stall_err  = stallErr;
    assign br_target  = id_pc4 + {{(DW-18){id_imm[15]}}, id_imm, 2'b00};

    // Leaving WAIT for any reason (resolve, force, abandon) returns to RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_RUN;
            stallCnt <= '0;
            stallErr <= 1'b0;
        end else begin
            if (stallNow) begin
                state    <= ST_WAIT;
                stallCnt <= stallCnt + CW'(1);
            end else begin
                state    <= ST_RUN;
                stallCnt <= '0;
            end
            if (forceNow) begin
                stallErr <= 1'b1;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] cntBranch, cntTaken, cntStall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cntBranch <= '0;
            cntTaken  <= '0;
            cntStall  <= '0;
        end else begin
            if (resolveNow) begin
                cntBranch <= cntBranch + 32'd1;
            end
            if (resolveNow && condTrue) begin
                cntTaken <= cntTaken + 32'd1;
            end
            if (stallNow) begin
                cntStall <= cntStall + 32'd1;
            end
        end
    end

    assign cnt_branch = cntBranch;
    assign cnt_taken  = cntTaken;
    assign cnt_stall  = cntStall;
`else
    assign cnt_branch = '0;
    assign cnt_taken  = '0;
    assign cnt_stall  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - self-checking bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;

    localparam int DW        = 32;
    localparam int RW        = 5;
    localparam int MAX_STALL = 2;

    logic          clk;
    logic          rst_n;
    logic          id_valid;
    logic [5:0]    id_op;
    logic [RW-1:0] id_rs, id_rt;
    logic [DW-1:0] id_pc4;
    logic [15:0]   id_imm;
    logic [DW-1:0] rs_data, rt_data;
    logic          ex_regwrite, ex_memread;
    logic [RW-1:0] ex_rd;
    logic          mem_regwrite, mem_memread;
    logic [RW-1:0] mem_rd;
    logic [DW-1:0] mem_alu;
    logic          stall, br_taken, ifid_flush, stall_err;
    logic [DW-1:0] br_target;
    logic [31:0]   cnt_branch, cnt_taken, cnt_stall;

    int checks = 0;
    int errors = 0;

    branch_resolve_ctrl #(.DW(DW), .RW(RW), .MAX_STALL(MAX_STALL)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .id_valid     (id_valid),
        .id_op        (id_op),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_pc4       (id_pc4),
        .id_imm       (id_imm),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .ex_rd        (ex_rd),
        .mem_regwrite (mem_regwrite),
        .mem_memread  (mem_memread),
        .mem_rd       (mem_rd),
        .mem_alu      (mem_alu),
        .stall        (stall),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .ifid_flush   (ifid_flush),
        .stall_err    (stall_err),
        .cnt_branch   (cnt_branch),
        .cnt_taken    (cnt_taken),
        .cnt_stall    (cnt_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic stall;
        logic resolve;
        logic taken;
        logic forced;
    } expT;

    int          heldStalls = 0;   // stall cycles already spent on the branch in ID
    logic        mErr = 1'b0;
    logic [31:0] mBr = 0, mTk = 0, mSt = 0;

    function automatic logic blocked(input logic [RW-1:0] s);
        if (s == 0) return 1'b0;
        return (ex_regwrite && ex_rd == s) || (mem_memread && mem_rd == s);
    endfunction

    function automatic logic [31:0] operand(input logic [RW-1:0] s, input logic [31:0] rf);
        if (s != 0 && mem_regwrite && !mem_memread && mem_rd == s && !(ex_regwrite && ex_rd == s))
            return mem_alu;
        return rf;
    endfunction

    function automatic expT predict();
        expT e;
        logic [31:0] a, b;
        logic hz;
        e = '0;
        if (rst_n !== 1'b1 || id_valid !== 1'b1) return e;
        if (!(id_op inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07})) return e;
        hz = blocked(id_rs) || ((id_op == 6'h04 || id_op == 6'h05) && blocked(id_rt));
        if (hz && heldStalls < MAX_STALL) begin
            e.stall = 1'b1;
            return e;
        end
        a = operand(id_rs, rs_data);
        b = operand(id_rt, rt_data);
        e.resolve = 1'b1;
        e.forced  = hz;
        case (id_op)
            6'h01:   e.taken = $signed(a) < 0;
            6'h04:   e.taken = (a == b);
            6'h05:   e.taken = (a != b);
            6'h06:   e.taken = $signed(a) <= 0;
            default: e.taken = $signed(a) > 0;
        endcase
        return e;
    endfunction

    always @(posedge clk) begin : model_update
        expT e;
        if (!rst_n) begin
            heldStalls <= 0;
            mErr       <= 1'b0;
            mBr        <= 0;
            mTk        <= 0;
            mSt        <= 0;
        end else begin
            e = predict();
            heldStalls <= e.stall ? heldStalls + 1 : 0;
            if (e.forced) mErr <= 1'b1;
            mBr <= mBr + 32'(e.resolve);
            mTk <= mTk + 32'(e.resolve && e.taken);
            mSt <= mSt + 32'(e.stall);
        end
    end

    always @(negedge clk) begin : compare
        expT e;
        e = predict();
        check("m_stall",      32'(stall),      32'(e.stall));
        check("m_br_taken",   32'(br_taken),   32'(e.taken));
        check("m_ifid_flush", 32'(ifid_flush), 32'(e.taken));
        check("m_br_target",  br_target,       id_pc4 + 32'($signed(id_imm)) * 4);
        check("m_stall_err",  32'(stall_err),  32'(rst_n ? mErr : 1'b0));
`ifdef BRANCH_STATS_EN
        check("m_cnt_branch", cnt_branch, rst_n ? mBr : 32'd0);
        check("m_cnt_taken",  cnt_taken,  rst_n ? mTk : 32'd0);
        check("m_cnt_stall",  cnt_stall,  rst_n ? mSt : 32'd0);
`else
        check("m_cnt_branch", cnt_branch, 32'd0);
        check("m_cnt_taken",  cnt_taken,  32'd0);
        check("m_cnt_stall",  cnt_stall,  32'd0);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic exSet(input logic rw, input logic mr, input logic [RW-1:0] rd);
        ex_regwrite = rw; ex_memread = mr; ex_rd = rd;
    endtask

    task automatic memSet(input logic rw, input logic mr, input logic [RW-1:0] rd, input logic [31:0] alu);
        mem_regwrite = rw; mem_memread = mr; mem_rd = rd; mem_alu = alu;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_op = '0; id_rs = '0; id_rt = '0; id_pc4 = '0; id_imm = '0;
        rs_data = '0; rt_data = '0;
        exSet(1'b0, 1'b0, '0);
        memSet(1'b0, 1'b0, '0, '0);
    endtask

    task automatic br(input logic [5:0] op, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                      input logic [31:0] rsd, input logic [31:0] rtd,
                      input logic [31:0] pc4, input logic [15:0] imm);
        idle();
        id_valid = 1'b1; id_op = op; id_rs = rs; id_rt = rt;
        rs_data = rsd; rt_data = rtd; id_pc4 = pc4; id_imm = imm;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    logic [31:0] fwdVals [3] = '{32'h0000_0001, 32'h0000_0000, 32'h8000_0000};
    logic        fwdExp  [3] = '{1'b1, 1'b0, 1'b0};

    initial begin
        idle();
        rst_n = 1'b0;
        settle();
        check("rst_stall",      32'(stall),      32'd0);
        check("rst_br_taken",   32'(br_taken),   32'd0);
        check("rst_stall_err",  32'(stall_err),  32'd0);
        check("rst_cnt_branch", cnt_branch,      32'd0);
        advance();
        rst_n = 1'b1;

        // BEQ equal, no hazard, negative offset
        advance(); br(6'h04, 5'd1, 5'd2, 32'h1234_5678, 32'h1234_5678, 32'h100, 16'hFFFE);
        settle();
        check("beq_taken",  32'(br_taken),   32'd1);
        check("beq_flush",  32'(ifid_flush), 32'd1);
        check("beq_stall",  32'(stall),      32'd0);
        check("beq_target", br_target,       32'h0000_00F8);

        // BNE with EX ALU producer: one stall, then forwarded 5 vs 5
        advance(); br(6'h05, 5'd3, 5'd5, 32'd0, 32'd5, 32'h140, 16'h0010); exSet(1'b1, 1'b0, 5'd3);
        settle(); check("bne_stall_c1", 32'(stall), 32'd1);
        advance(); exSet(1'b0, 1'b0, '0); memSet(1'b1, 1'b0, 5'd3, 32'd5);
        settle();
        check("bne_stall_c2", 32'(stall),    32'd0);
        check("bne_taken",    32'(br_taken), 32'd0);

        // BLTZ with EX load: two stalls, then register file value
        advance(); br(6'h01, 5'd4, 5'd0, 32'd0, 32'd0, 32'h200, 16'h0004); exSet(1'b1, 1'b1, 5'd4);
        settle(); check("bltz_stall_c1", 32'(stall), 32'd1);
        advance(); exSet(1'b0, 1'b0, '0); memSet(1'b1, 1'b1, 5'd4, 32'hDEAD_BEEF);
        settle(); check("bltz_stall_c2", 32'(stall), 32'd1);
        advance(); memSet(1'b0, 1'b0, '0, '0); rs_data = 32'h8000_0000;
        settle();
        check("bltz_stall_c3", 32'(stall),    32'd0);
        check("bltz_taken",    32'(br_taken), 32'd1);
        check("bltz_target",   br_target,     32'h0000_0210);

        // BGTZ on forwarded MEM ALU result, register file holds stale -1
        for (int i = 0; i < 3; i++) begin
            advance(); br(6'h07, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'h300, 16'h0001);
            memSet(1'b1, 1'b0, 5'd2, fwdVals[i]);
            settle();
            check("bgtz_fwd_stall", 32'(stall),    32'd0);
            check("bgtz_fwd_taken", 32'(br_taken), 32'(fwdExp[i]));
        end

        // $0 is never hazardous
        advance(); br(6'h04, 5'd0, 5'd0, 32'd0, 32'd0, 32'h400, 16'h0000); exSet(1'b1, 1'b0, 5'd0);
        settle();
        check("r0_stall", 32'(stall),    32'd0);
        check("r0_taken", 32'(br_taken), 32'd1);

        // Hazard held past MAX_STALL: forced resolve and sticky stall_err
        advance(); br(6'h04, 5'd7, 5'd8, 32'd1, 32'd1, 32'h500, 16'h0002); exSet(1'b1, 1'b0, 5'd7);
        settle(); check("ovf_stall_c1", 32'(stall), 32'd1);
        advance();
        settle(); check("ovf_stall_c2", 32'(stall), 32'd1);
        check("ovf_err_early", 32'(stall_err), 32'd0);
        advance();
        settle();
        check("ovf_forced_stall", 32'(stall),    32'd0);
        check("ovf_forced_taken", 32'(br_taken), 32'd1);
        advance(); idle();
        settle(); check("ovf_err_set", 32'(stall_err), 32'd1);

        // Abandon in WAIT, then a fresh branch
        advance(); br(6'h05, 5'd9, 5'd10, 32'd1, 32'd2, 32'h600, 16'h0003); exSet(1'b1, 1'b0, 5'd9);
        settle(); check("abn_stall", 32'(stall), 32'd1);
        advance(); idle();
        settle(); check("abn_taken", 32'(br_taken), 32'd0);
        advance(); br(6'h05, 5'd9, 5'd10, 32'd1, 32'd2, 32'h600, 16'h0003);
        settle(); check("abn_next_taken", 32'(br_taken), 32'd1);

        // Reset asserted in the middle of a WAIT
        advance(); br(6'h05, 5'd11, 5'd12, 32'd1, 32'd2, 32'h700, 16'h0000); exSet(1'b1, 1'b1, 5'd11);
        settle(); check("rstw_stall", 32'(stall), 32'd1);
        advance(); exSet(1'b0, 1'b0, '0); memSet(1'b1, 1'b1, 5'd11, 32'd0); rst_n = 1'b0;
        settle();
        check("rstw_stall_low", 32'(stall),      32'd0);
        check("rstw_taken_low", 32'(br_taken),   32'd0);
        check("rstw_flush_low", 32'(ifid_flush), 32'd0);
        check("rstw_err_low",   32'(stall_err),  32'd0);
        advance(); idle(); rst_n = 1'b1;

        // Statistics: three branches, two taken, one with two stalls
        advance(); br(6'h04, 5'd1, 5'd2, 32'd9, 32'd9, 32'h800, 16'h0001);
        advance(); br(6'h01, 5'd4, 5'd0, 32'd0, 32'd0, 32'h900, 16'h0001); exSet(1'b1, 1'b1, 5'd4);
        advance(); exSet(1'b0, 1'b0, '0); memSet(1'b1, 1'b1, 5'd4, 32'd0);
        advance(); memSet(1'b0, 1'b0, '0, '0); rs_data = 32'h8000_0000;
        advance(); br(6'h05, 5'd3, 5'd5, 32'd5, 32'd5, 32'hA00, 16'h0001);
        advance(); idle();
        settle();
`ifdef BRANCH_STATS_EN
        check("stats_branch", cnt_branch, 32'd3);
        check("stats_taken",  cnt_taken,  32'd2);
        check("stats_stall",  cnt_stall,  32'd2);
`else
        check("stats_branch", cnt_branch, 32'd0);
        check("stats_taken",  cnt_taken,  32'd0);
        check("stats_stall",  cnt_stall,  32'd0);
`endif

        // Target wraps modulo 2^32
        advance(); br(6'h04, 5'd1, 5'd2, 32'd0, 32'd0, 32'hFFFF_FFFC, 16'h0001);
        settle(); check("wrap_target", br_target, 32'h0000_0000);

        // BLEZ on zero and on +1
        advance(); br(6'h06, 5'd6, 5'd0, 32'd0, 32'd0, 32'hB00, 16'h0001);
        settle(); check("blez_zero", 32'(br_taken), 32'd1);
        advance(); br(6'h06, 5'd6, 5'd0, 32'd1, 32'd0, 32'hB00, 16'h0001);
        settle(); check("blez_pos", 32'(br_taken), 32'd0);

        // Non-branch opcode with a matching EX producer stays idle
        advance(); br(6'h23, 5'd3, 5'd4, 32'd0, 32'd0, 32'hC00, 16'h0001); exSet(1'b1, 1'b0, 5'd3);
        settle(); check("nonbr_stall", 32'(stall), 32'd0);

        advance(); idle();
        settle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
